win_scan_checker: RTL and testbench

//  Parametrised, sequential N-in-a-row detector for the Connect-style game board.
//  On a start request it snapshots the board and scans one anchor cell per clock.
//  It reports the first winning line: player, anchor row/col and direction.

---
 rtl/win_chk_pkg.sv | 25 ++
 rtl/win_line_eval.sv | 63 ++++++
 rtl/win_scan_checker.sv | 198 +++++++++++++++++++
 tb/tb_win_scan_checker.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/win_chk_pkg.sv
// Shared types for the N-in-a-row scan checker: line directions, FSM states and cell constants.
package win_chk_pkg;

   typedef enum logic [1:0] {
      DIR_H  = 2'd0,
      DIR_V  = 2'd1,
      DIR_DR = 2'd2,
      DIR_UR = 2'd3
   } dir_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SNAP = 2'd1,
      ST_SCAN = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int unsigned EMPTY_CELL = 0;

   // Index width that stays at least one bit for degenerate sizes
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/win_line_eval.sv
// Combinational line check for one anchor cell; reports the first direction
// (H > V > DR > UR) whose WIN_LEN-long in-bounds run matches the anchor.
module win_line_eval
   import win_chk_pkg::*;
#(
   parameter int unsigned ROWS    = 6,
   parameter int unsigned COLS    = 7,
   parameter int unsigned WIN_LEN = 4,
   parameter int unsigned PW      = 2
) (
   input  logic [PW-1:0]             snap_i [ROWS][COLS],
   input  logic [idx_w(ROWS)-1:0]    row_i,
   input  logic [idx_w(COLS)-1:0]    col_i,
   output logic                      hit_o,
   output dir_e                      dir_o
);

   localparam int unsigned RW = idx_w(ROWS);
   localparam int unsigned CW = idx_w(COLS);

   logic [PW-1:0] anchor;
   logic          h_ok;
   logic          v_ok;
   logic          dr_ok;
   logic          ur_ok;
   logic          fit_right;
   logic          fit_down;
   logic          fit_up;

   always_comb begin
      anchor    = snap_i[row_i][col_i];
      fit_right = (32'(col_i) + WIN_LEN) <= COLS;
      fit_down  = (32'(row_i) + WIN_LEN) <= ROWS;
      fit_up    = (32'(row_i) + 32'd1) >= WIN_LEN;
      h_ok      = (anchor != PW'(EMPTY_CELL)) && fit_right;
      v_ok      = (anchor != PW'(EMPTY_CELL)) && fit_down;
      dr_ok     = (anchor != PW'(EMPTY_CELL)) && fit_right && fit_down;
      ur_ok     = (anchor != PW'(EMPTY_CELL)) && fit_right && fit_up;
      // Bounds gate every run, so wrapped indices below never affect a result
      for (int unsigned i = 1; i < WIN_LEN; i++) begin
         if (snap_i[row_i][CW'(32'(col_i) + i)] != anchor)
            h_ok = 1'b0;
         if (snap_i[RW'(32'(row_i) + i)][col_i] != anchor)
            v_ok = 1'b0;
         if (snap_i[RW'(32'(row_i) + i)][CW'(32'(col_i) + i)] != anchor)
            dr_ok = 1'b0;
         if (snap_i[RW'(32'(row_i) - i)][CW'(32'(col_i) + i)] != anchor)
            ur_ok = 1'b0;
      end
   end

   always_comb begin
      hit_o = h_ok | v_ok | dr_ok | ur_ok;
      dir_o = DIR_UR;
      if (h_ok)
         dir_o = DIR_H;
      else if (v_ok)
         dir_o = DIR_V;
      else if (dr_ok)
         dir_o = DIR_DR;
   end

endmodule

// File: rtl/win_scan_checker.sv
// Sequential N-in-a-row detector: snapshots the board, scans one anchor per clock
// and reports the first winning line. Optional draw detection: WIN_SCAN_DRAW_DETECT_EN.
module win_scan_checker
   import win_chk_pkg::*;
#(
   parameter int unsigned ROWS    = 6,
   parameter int unsigned COLS    = 7,
   parameter int unsigned WIN_LEN = 4,
   parameter int unsigned PW      = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [PW-1:0]          board [ROWS][COLS],
   output logic                   busy,
   output logic                   done,
   output logic                   win_flag,
   output logic [PW-1:0]          winner_id,
   output logic [idx_w(ROWS)-1:0] win_row,
   output logic [idx_w(COLS)-1:0] win_col,
   output dir_e                   win_dir,
   output logic                   draw_flag
);

   localparam int unsigned CELLS = ROWS * COLS;
   localparam int unsigned KW    = idx_w(CELLS);
   localparam int unsigned RW    = idx_w(ROWS);
   localparam int unsigned CW    = idx_w(COLS);

   state_e        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          win_q, win_d;
   logic [PW-1:0] winner_q, winner_d;
   logic [RW-1:0] wrow_q, wrow_d;
   logic [CW-1:0] wcol_q, wcol_d;
   dir_e          wdir_q, wdir_d;
   logic [PW-1:0] snap_q [ROWS][COLS];

   logic          hit;
   dir_e          hit_dir;
   logic          last_cell;
   logic [PW-1:0] anchor_cell;

   win_line_eval #(
      .ROWS    (ROWS),
      .COLS    (COLS),
      .WIN_LEN (WIN_LEN),
      .PW      (PW)
   ) u_eval (
      .snap_i (snap_q),
      .row_i  (row_q),
      .col_i  (col_q),
      .hit_o  (hit),
      .dir_o  (hit_dir)
   );

   assign last_cell   = (k_q == KW'(CELLS - 1));
   assign anchor_cell = snap_q[row_q][col_q];

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      row_d    = row_q;
      col_d    = col_q;
      win_d    = win_q;
      winner_d = winner_q;
      wrow_d   = wrow_q;
      wcol_d   = wcol_q;
      wdir_d   = wdir_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SNAP;
               k_d     = '0;
               row_d   = '0;
               col_d   = '0;
            end
         end
         ST_SNAP: begin
            state_d  = ST_SCAN;
            win_d    = 1'b0;
            winner_d = '0;
         end
         ST_SCAN: begin
            if (hit) begin
               state_d  = ST_DONE;
               win_d    = 1'b1;
               winner_d = anchor_cell;
               wrow_d   = row_q;
               wcol_d   = col_q;
               wdir_d   = hit_dir;
            end else if (last_cell) begin
               state_d = ST_DONE;
            end else begin
               k_d = k_q + KW'(1);
               if (col_q == CW'(COLS - 1)) begin
                  col_d = '0;
                  row_d = row_q + RW'(1);
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_SNAP) || (state_d == ST_SCAN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         k_q      <= '0;
         row_q    <= '0;
         col_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         win_q    <= 1'b0;
         winner_q <= '0;
         wrow_q   <= '0;
         wcol_q   <= '0;
         wdir_q   <= DIR_H;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         row_q    <= row_d;
         col_q    <= col_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         win_q    <= win_d;
         winner_q <= winner_d;
         wrow_q   <= wrow_d;
         wcol_q   <= wcol_d;
         wdir_q   <= wdir_d;
      end
   end

   // Board is captured once; later board changes cannot disturb the scan
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < int'(ROWS); r++)
            for (int c = 0; c < int'(COLS); c++)
               snap_q[r][c] <= '0;
      end else if (state_q == ST_SNAP) begin
         snap_q <= board;
      end
   end

`ifdef WIN_SCAN_DRAW_DETECT_EN
   logic seen_empty_q, seen_empty_d;
   logic draw_q, draw_d;
   logic anchor_empty;

   assign anchor_empty = (anchor_cell == PW'(EMPTY_CELL));

   // A full scan without a hit visits every cell, so anchor checks cover the board
   always_comb begin
      seen_empty_d = seen_empty_q;
      draw_d       = draw_q;
      if (state_q == ST_SNAP) begin
         seen_empty_d = 1'b0;
         draw_d       = 1'b0;
      end else if (state_q == ST_SCAN) begin
         seen_empty_d = seen_empty_q | anchor_empty;
         if (!hit && last_cell)
            draw_d = !(seen_empty_q | anchor_empty);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seen_empty_q <= 1'b0;
         draw_q       <= 1'b0;
      end else begin
         seen_empty_q <= seen_empty_d;
         draw_q       <= draw_d;
      end
   end

   assign draw_flag = draw_q;
`else
   assign draw_flag = 1'b0;
`endif

   assign busy      = busy_q;
   assign done      = done_q;
   assign win_flag  = win_q;
   assign winner_id = winner_q;
   assign win_row   = wrow_q;
   assign win_col   = wcol_q;
   assign win_dir   = wdir_q;

endmodule

// File: tb/tb_win_scan_checker.sv
// Directed bench for win_scan_checker: 6x7/4 instance plus an 8x8/5 instance.
module tb_win_scan_checker;
   import win_chk_pkg::*;

`ifdef WIN_SCAN_DRAW_DETECT_EN
   localparam logic EXP_DRAW = 1'b1;
`else
   localparam logic EXP_DRAW = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] board [6][7];
   logic       busy, done, win_flag, draw_flag;
   logic [1:0] winner_id;
   logic [2:0] win_row, win_col;
   dir_e       win_dir;

   logic       start8;
   logic [1:0] board8 [8][8];
   logic       busy8, done8, win_flag8, draw_flag8;
   logic [1:0] winner_id8;
   logic [2:0] win_row8, win_col8;
   dir_e       win_dir8;

   int n_pass   = 0;
   int n_checks = 0;

   always #5 clk = ~clk;

   win_scan_checker #(.ROWS(6), .COLS(7), .WIN_LEN(4), .PW(2)) dut (
      .clk(clk), .rst(rst), .start(start), .board(board),
      .busy(busy), .done(done), .win_flag(win_flag), .winner_id(winner_id),
      .win_row(win_row), .win_col(win_col), .win_dir(win_dir), .draw_flag(draw_flag)
   );

   win_scan_checker #(.ROWS(8), .COLS(8), .WIN_LEN(5), .PW(2)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .board(board8),
      .busy(busy8), .done(done8), .win_flag(win_flag8), .winner_id(winner_id8),
      .win_row(win_row8), .win_col(win_col8), .win_dir(win_dir8), .draw_flag(draw_flag8)
   );

   // Result tuple order: flag, id, row, col, dir, draw
   function automatic logic [11:0] res6();
      return {win_flag, winner_id, win_row, win_col, win_dir, draw_flag};
   endfunction

   task automatic clear_board();
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++)
            board[r][c] = 2'd0;
   endtask

   // Cycle 1 is the edge that samples start; returns the cycle on which done is seen
   task automatic run_scan(output int cyc, output bit timed_out);
      @(negedge clk); start = 1'b1;
      @(posedge clk); cyc = 1;
      @(negedge clk); start = 1'b0;
      timed_out = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); cyc++;
         @(negedge clk);
         if (done) begin timed_out = 1'b0; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; start8 = 1'b0;
      clear_board();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            board8[r][c] = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({busy, done, res6()} !== 14'd0)
         $display("FAIL reset_outputs got %h want 0", {busy, done, res6()});
      else n_pass++;
      n_checks++;
      if ({busy8, done8, win_flag8, winner_id8, win_row8, win_col8, win_dir8, draw_flag8} !== 14'd0)
         $display("FAIL reset_outputs8 got %h want 0",
                  {busy8, done8, win_flag8, winner_id8, win_row8, win_col8, win_dir8, draw_flag8});
      else n_pass++;
      rst = 1'b1;
   endtask

   task automatic test_empty();
      int cyc; bit to;
      clear_board();
      run_scan(cyc, to);
      n_checks++;
      if (to || cyc != 44) $display("FAIL empty_latency got %0d (timeout=%0d) want 44", cyc, to);
      else n_pass++;
      n_checks++;
      if ({win_flag, winner_id, draw_flag, busy} !== 5'b0)
         $display("FAIL empty_result got flag=%0d id=%0d draw=%0d busy=%0d want 0 0 0 0",
                  win_flag, winner_id, draw_flag, busy);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) $display("FAIL done_pulse_width got %0d want 0", done);
      else n_pass++;
   endtask

   task automatic test_horizontal();
      int cyc; bit to;
      clear_board();
      for (int c = 2; c <= 5; c++) board[5][c] = 2'd1;
      run_scan(cyc, to);
      n_checks++;
      if (to || cyc != 40) $display("FAIL horiz_latency got %0d (timeout=%0d) want 40", cyc, to);
      else n_pass++;
      n_checks++;
      if (res6() !== {1'b1, 2'd1, 3'd5, 3'd2, DIR_H, 1'b0})
         $display("FAIL horiz_result got %h want %h", res6(), {1'b1, 2'd1, 3'd5, 3'd2, DIR_H, 1'b0});
      else n_pass++;
   endtask

   task automatic test_scan_order();
      int cyc; bit to;
      clear_board();
      for (int i = 0; i < 4; i++) begin board[i][0] = 2'd2; board[5][i] = 2'd1; end
      run_scan(cyc, to);
      n_checks++;
      if (to || cyc != 3) $display("FAIL order_latency got %0d (timeout=%0d) want 3", cyc, to);
      else n_pass++;
      n_checks++;
      if (res6() !== {1'b1, 2'd2, 3'd0, 3'd0, DIR_V, 1'b0})
         $display("FAIL order_result got %h want %h", res6(), {1'b1, 2'd2, 3'd0, 3'd0, DIR_V, 1'b0});
      else n_pass++;
   endtask

   task automatic test_priority();
      int cyc; bit to;
      clear_board();
      for (int i = 0; i < 4; i++) begin board[0][i] = 2'd1; board[i][0] = 2'd1; end
      run_scan(cyc, to);
      n_checks++;
      if (to || res6() !== {1'b1, 2'd1, 3'd0, 3'd0, DIR_H, 1'b0})
         $display("FAIL prio_h_over_v got %h want %h", res6(), {1'b1, 2'd1, 3'd0, 3'd0, DIR_H, 1'b0});
      else n_pass++;
   endtask

   task automatic test_diagonals();
      int cyc; bit to;
      clear_board();
      for (int i = 0; i < 4; i++) board[5-i][i] = 2'd1;
      run_scan(cyc, to);
      n_checks++;
      if (to || cyc != 38) $display("FAIL ur_latency got %0d (timeout=%0d) want 38", cyc, to);
      else n_pass++;
      n_checks++;
      if (res6() !== {1'b1, 2'd1, 3'd5, 3'd0, DIR_UR, 1'b0})
         $display("FAIL ur_result got %h want %h", res6(), {1'b1, 2'd1, 3'd5, 3'd0, DIR_UR, 1'b0});
      else n_pass++;
      clear_board();
      for (int i = 0; i < 4; i++) board[i][3+i] = 2'd1;
      run_scan(cyc, to);
      n_checks++;
      if (to || cyc != 6) $display("FAIL dr_latency got %0d (timeout=%0d) want 6", cyc, to);
      else n_pass++;
      n_checks++;
      if (res6() !== {1'b1, 2'd1, 3'd0, 3'd3, DIR_DR, 1'b0})
         $display("FAIL dr_result got %h want %h", res6(), {1'b1, 2'd1, 3'd0, 3'd3, DIR_DR, 1'b0});
      else n_pass++;
   endtask

   // Runs that would only complete by wrapping past an edge must not hit
   task automatic test_bounds();
      int cyc; bit to;
      clear_board();
      for (int c = 4; c < 7; c++) board[0][c] = 2'd1;
      board[1][0] = 2'd1;
      for (int r = 3; r < 6; r++) board[r][6] = 2'd2;
      board[2][0] = 2'd2; board[1][1] = 2'd2; board[0][2] = 2'd2;
      run_scan(cyc, to);
      n_checks++;
      if (to || cyc != 44 || win_flag !== 1'b0 || winner_id !== 2'd0)
         $display("FAIL bounds_no_wrap got cyc=%0d flag=%0d id=%0d want cyc=44 flag=0 id=0",
                  cyc, win_flag, winner_id);
      else n_pass++;
   endtask

   task automatic test_draw();
      int cyc; bit to;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++)
            board[r][c] = 2'(1 + (((c >> 1) + r) % 2));
      run_scan(cyc, to);
      n_checks++;
      if (to || cyc != 44 || {win_flag, winner_id, draw_flag} !== {1'b0, 2'd0, EXP_DRAW})
         $display("FAIL draw_full_board got cyc=%0d flag=%0d id=%0d draw=%0d want cyc=44 0 0 %0d",
                  cyc, win_flag, winner_id, draw_flag, EXP_DRAW);
      else n_pass++;
   endtask

   task automatic test_reset_mid_scan();
      int pulses;
      clear_board();
      for (int c = 0; c < 4; c++) board[3][c] = 2'd2;
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (11) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL midscan_busy got %0d want 1", busy);
      else n_pass++;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, res6()} !== 14'd0)
         $display("FAIL midscan_reset got %h want 0", {busy, done, res6()});
      else n_pass++;
      @(negedge clk); rst = 1'b1;
      pulses = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      n_checks++;
      if (pulses != 0) $display("FAIL midscan_no_done got %0d active cycles want 0", pulses);
      else n_pass++;
   endtask

   task automatic test_snapshot_busy_start();
      int cyc; bit to;
      clear_board();
      for (int c = 2; c <= 5; c++) board[5][c] = 2'd1;
      @(negedge clk); start = 1'b1;
      @(posedge clk); cyc = 1;
      @(negedge clk); start = 1'b0;
      @(posedge clk); cyc++;
      @(negedge clk);
      clear_board();
      for (int c = 0; c < 4; c++) board[0][c] = 2'd2;
      to = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); cyc++;
         @(negedge clk);
         start = (cyc == 20 || cyc == 21);
         if (done) begin to = 1'b0; break; end
      end
      start = 1'b0;
      n_checks++;
      if (to || cyc != 40 || res6() !== {1'b1, 2'd1, 3'd5, 3'd2, DIR_H, 1'b0})
         $display("FAIL snapshot_hold got cyc=%0d res=%h want cyc=40 res=%h",
                  cyc, res6(), {1'b1, 2'd1, 3'd5, 3'd2, DIR_H, 1'b0});
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({busy, done} !== 2'b00) $display("FAIL busy_start_queued got busy=%0d done=%0d want 0 0", busy, done);
         else n_pass++;
      end
   endtask

   task automatic test_start_held();
      int cyc; bit to;
      clear_board();
      for (int i = 0; i < 4; i++) board[i][3+i] = 2'd1;
      @(negedge clk); start = 1'b1;
      @(posedge clk); cyc = 1;
      to = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); cyc++;
         @(negedge clk);
         if (done) begin to = 1'b0; break; end
      end
      n_checks++;
      if (to || cyc != 6) $display("FAIL held_latency got %0d (timeout=%0d) want 6", cyc, to);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL held_idle_busy got %0d want 0", busy);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL held_restart got busy=%0d want 1", busy);
      else n_pass++;
      start = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin to = 1'b0; break; end
      end
      n_checks++;
      if (to || res6() !== {1'b1, 2'd1, 3'd0, 3'd3, DIR_DR, 1'b0})
         $display("FAIL held_rescan got res=%h (timeout=%0d) want %h", res6(), to,
                  {1'b1, 2'd1, 3'd0, 3'd3, DIR_DR, 1'b0});
      else n_pass++;
   endtask

   task automatic test_large_board();
      int cyc; bit to;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            board8[r][c] = 2'd0;
      for (int c = 0; c < 4; c++) board8[0][c] = 2'd1;
      for (int c = 3; c < 8; c++) board8[7][c] = 2'd3;
      @(negedge clk); start8 = 1'b1;
      @(posedge clk); cyc = 1;
      @(negedge clk); start8 = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); cyc++;
         @(negedge clk);
         if (done8) begin to = 1'b0; break; end
      end
      n_checks++;
      if (to || cyc != 62) $display("FAIL large_latency got %0d (timeout=%0d) want 62", cyc, to);
      else n_pass++;
      n_checks++;
      if ({win_flag8, winner_id8, win_row8, win_col8, win_dir8, draw_flag8}
          !== {1'b1, 2'd3, 3'd7, 3'd3, DIR_H, 1'b0})
         $display("FAIL large_result got %h want %h",
                  {win_flag8, winner_id8, win_row8, win_col8, win_dir8, draw_flag8},
                  {1'b1, 2'd3, 3'd7, 3'd3, DIR_H, 1'b0});
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_empty();
      test_horizontal();
      test_scan_order();
      test_priority();
      test_diagonals();
      test_bounds();
      test_draw();
      test_reset_mid_scan();
      test_snapshot_busy_start();
      test_start_held();
      test_large_board();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
